// File: rtl/adc_chan_sched_if.sv
// Handshake bundle between the ADC conversion scheduler, the spi_ad7324 front end and the
// consumer of the per-channel results.
interface adc_chan_sched_if #(
    parameter int M = 12
);
    logic         EN;
    logic         HOLD;
    logic [1:0]   CH_SEL;
    logic         SPI_DONE;
    logic [15:0]  DATA_READ;
    logic [M-1:0] VOUT;
    logic [M-1:0] TEMP;
    logic [M-1:0] VIN;
    logic [M-1:0] IOUT;
    logic [3:0]   VALID;
    logic         CH_ERR;
    logic         TO_ERR;
    logic         ERR_CLR;

    modport master (
        input  EN, SPI_DONE, DATA_READ, ERR_CLR,
        output HOLD, CH_SEL, VOUT, TEMP, VIN, IOUT, VALID, CH_ERR, TO_ERR
    );

    modport slave (
        output EN, SPI_DONE, DATA_READ, ERR_CLR,
        input  HOLD, CH_SEL, VOUT, TEMP, VIN, IOUT, VALID, CH_ERR, TO_ERR
    );
endinterface

// File: rtl/adc_chan_sched.sv
// AD7324 channel scheduler: issues HOLD per schedule slot, captures and checks returned frames.
// Define ADC_VOUT_PRIORITY_EN for the 6-slot Vout-priority schedule (default: 4-slot round robin).
module adc_chan_sched #(
    parameter int M       = 12,
    parameter int GAP     = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              CLK20M,
    input  logic              RSTn,
    adc_chan_sched_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_CAPTURE,
        S_GAP
    } state_e;

`ifdef ADC_VOUT_PRIORITY_EN
    localparam int NSLOT = 6;
`else
    localparam int NSLOT = 4;
`endif
    localparam int PW   = $clog2(NSLOT);
    localparam int CMAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [CW-1:0] TO_LAST   = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] GAP_LAST  = CW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [PW-1:0] SLOT_LAST = PW'(NSLOT - 1);
    localparam logic [M-1:0]  MSB_FLIP  = M'(1) << (M - 1);

    if (M < 1 || M > 12) begin : g_bad_m
        $error("adc_chan_sched: M must be in 1..12");
    end

    function automatic logic [1:0] slot_ch(input logic [PW-1:0] slot);
`ifdef ADC_VOUT_PRIORITY_EN
        case (slot)
            3'd1:    return 2'd1;
            3'd3:    return 2'd2;
            3'd5:    return 2'd3;
            default: return 2'd0;
        endcase
`else
        return slot;
`endif
    endfunction

    state_e         state_q, state_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [M-1:0]   res_q [4];
    logic [M-1:0]   res_d [4];
    logic [3:0]     valid_q, valid_d;
    logic           ch_err_q, ch_err_d;
    logic           to_err_q, to_err_d;

    logic [1:0]     ch_sel;
    logic [M-1:0]   result;
    logic           leave_conv;
    logic           end_gap;
    logic           unused_frame;

    assign ch_sel       = slot_ch(ptr_q);
    // Two's complement to offset binary is a flip of the kept MSB.
    assign result       = bus.DATA_READ[12 -: M] ^ MSB_FLIP;
    assign unused_frame = ^bus.DATA_READ;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = '0;
        res_d      = res_q;
        valid_d    = '0;
        ch_err_d   = ch_err_q & ~bus.ERR_CLR;
        to_err_d   = to_err_q & ~bus.ERR_CLR;
        leave_conv = 1'b0;
        end_gap    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.EN) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Result is written on the SPI_DONE edge so VALID lands in the CAPTURE cycle.
                if (bus.SPI_DONE) begin
                    state_d = S_CAPTURE;
                    if (bus.DATA_READ[14:13] == ch_sel) begin
                        res_d[ch_sel]   = result;
                        valid_d[ch_sel] = 1'b1;
                    end else begin
                        ch_err_d = 1'b1;
                    end
                end else if (cnt_q == TO_LAST) begin
                    to_err_d   = 1'b1;
                    leave_conv = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_CAPTURE: begin
                leave_conv = 1'b1;
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    end_gap = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (leave_conv) begin
            if (GAP == 0) begin
                end_gap = 1'b1;
            end else begin
                state_d = S_GAP;
            end
        end

        if (end_gap) begin
            ptr_d   = (ptr_q == SLOT_LAST) ? '0 : ptr_q + PW'(1);
            state_d = bus.EN ? S_START : S_IDLE;
        end
    end

    always_ff @(posedge CLK20M or negedge RSTn) begin
        if (!RSTn) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            res_q    <= '{default: '0};
            valid_q  <= '0;
            ch_err_q <= 1'b0;
            to_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            valid_q  <= valid_d;
            ch_err_q <= ch_err_d;
            to_err_q <= to_err_d;
        end
    end

    // CH_SEL derives from the slot pointer, which only moves at the end of GAP.
    assign bus.HOLD   = (state_q == S_START);
    assign bus.CH_SEL = ch_sel;
    assign bus.VOUT   = res_q[0];
    assign bus.TEMP   = res_q[1];
    assign bus.VIN    = res_q[2];
    assign bus.IOUT   = res_q[3];
    assign bus.VALID  = valid_q;
    assign bus.CH_ERR = ch_err_q;
    assign bus.TO_ERR = to_err_q;

endmodule

// File: tb/tb_adc_chan_sched.sv
// Directed bench for adc_chan_sched: schedule order, capture/convert, ID error, timeout,
// EN drop and mid-conversion reset. Follows ADC_VOUT_PRIORITY_EN like the design.
module tb_adc_chan_sched;

    localparam int M       = 12;
    localparam int GAP     = 4;
    localparam int TIMEOUT = 64;

`ifdef ADC_VOUT_PRIORITY_EN
    localparam int NSLOT = 6;
    logic [1:0] sched [6] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd3};
`else
    localparam int NSLOT = 4;
    logic [1:0] sched [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    adc_chan_sched_if #(.M(M)) bus ();

    adc_chan_sched #(
        .M       (M),
        .GAP     (GAP),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK20M (clk),
        .RSTn   (rstn),
        .bus    (bus)
    );

    int nvec = 0;
    int nerr = 0;
    int ptr  = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_hold(output int n);
        n = 0;
        while (bus.HOLD !== 1'b1 && n < 300) begin
            step();
            n++;
        end
        chk("hold_seen", 32'(bus.HOLD), 32'd1);
    endtask

    // SPI_DONE 20 cycles after the HOLD cycle; returns in the cycle after SPI_DONE.
    task automatic conv_done(input logic [15:0] frame);
        repeat (20) step();
        bus.SPI_DONE  = 1'b1;
        bus.DATA_READ = frame;
        step();
        bus.SPI_DONE  = 1'b0;
        bus.DATA_READ = '0;
        ptr = (ptr + 1) % NSLOT;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          cyc;
        int          nh;
        logic [1:0]  ch;
        logic [1:0]  wrong;
        logic [15:0] f;

        bus.EN        = 1'b0;
        bus.SPI_DONE  = 1'b0;
        bus.DATA_READ = '0;
        bus.ERR_CLR   = 1'b0;
        repeat (2) step();

        chk("rst_hold",   32'(bus.HOLD),   32'd0);
        chk("rst_ch_sel", 32'(bus.CH_SEL), 32'd0);
        chk("rst_vout",   32'(bus.VOUT),   32'd0);
        chk("rst_temp",   32'(bus.TEMP),   32'd0);
        chk("rst_vin",    32'(bus.VIN),    32'd0);
        chk("rst_iout",   32'(bus.IOUT),   32'd0);
        chk("rst_valid",  32'(bus.VALID),  32'd0);
        chk("rst_ch_err", 32'(bus.CH_ERR), 32'd0);
        chk("rst_to_err", 32'(bus.TO_ERR), 32'd0);

        // SPI_DONE while idle is ignored
        rstn          = 1'b1;
        bus.SPI_DONE  = 1'b1;
        bus.DATA_READ = 16'h1FFF;
        step();
        bus.SPI_DONE  = 1'b0;
        bus.DATA_READ = '0;
        step();
        chk("stray_valid", 32'(bus.VALID), 32'd0);
        chk("stray_vout",  32'(bus.VOUT),  32'd0);
        chk("idle_hold",   32'(bus.HOLD),  32'd0);

        bus.EN = 1'b1;
        wait_hold(cyc);
        chk("first_hold_cyc", 32'(cyc), 32'd1);
        chk("first_ch_sel",   32'(bus.CH_SEL), 32'd0);
        conv_done(16'h1000);
        chk("neg_full_vout",  32'(bus.VOUT),  32'h000);
        chk("neg_full_valid", 32'(bus.VALID), 32'h1);

        for (int i = 0; i < NSLOT; i++) begin
            wait_hold(cyc);
            chk("gap_spacing", 32'(cyc), 32'(GAP + 1));
            ch = sched[ptr];
            chk("sched_ch_sel", 32'(bus.CH_SEL), 32'(ch));
            f = (ch == 2'd0) ? 16'h0FFF : {1'b0, ch, 13'h0000};
            conv_done(f);
            chk("sched_valid", 32'(bus.VALID), 32'(4'b0001 << ch));
        end
        chk("pos_full_vout", 32'(bus.VOUT), 32'hFFF);
        chk("zero_temp",     32'(bus.TEMP), 32'h800);
        chk("zero_vin",      32'(bus.VIN),  32'h800);
        chk("zero_iout",     32'(bus.IOUT), 32'h800);

        // Temp slot answered with channel ID 2
        wait_hold(cyc);
        chk("err_ch_sel", 32'(bus.CH_SEL), 32'd1);
        conv_done({1'b0, 2'd2, 13'h0123});
        chk("ch_err_set",  32'(bus.CH_ERR), 32'd1);
        chk("ch_err_valid", 32'(bus.VALID), 32'd0);
        chk("ch_err_temp", 32'(bus.TEMP),   32'h800);
        chk("ch_err_vin",  32'(bus.VIN),    32'h800);
        bus.ERR_CLR = 1'b1;
        step();
        bus.ERR_CLR = 1'b0;
        chk("ch_err_clr", 32'(bus.CH_ERR), 32'd0);

        // Timeout: no SPI_DONE
        wait_hold(cyc);
        chk("to_ch_sel", 32'(bus.CH_SEL), 32'(sched[ptr]));
        repeat (TIMEOUT) step();
        chk("to_err_early", 32'(bus.TO_ERR), 32'd0);
        step();
        chk("to_err_set",   32'(bus.TO_ERR), 32'd1);
        chk("to_valid",     32'(bus.VALID),  32'd0);
        ptr = (ptr + 1) % NSLOT;
        wait_hold(cyc);
        chk("to_gap_cycles", 32'(cyc), 32'(GAP));
        chk("to_next_ch",    32'(bus.CH_SEL), 32'(sched[ptr]));

        // Wrong ID together with ERR_CLR: CH_ERR wins, TO_ERR clears
        repeat (20) step();
        wrong         = sched[ptr] + 2'd1;
        bus.SPI_DONE  = 1'b1;
        bus.DATA_READ = {1'b0, wrong, 13'h0000};
        bus.ERR_CLR   = 1'b1;
        step();
        bus.SPI_DONE  = 1'b0;
        bus.DATA_READ = '0;
        bus.ERR_CLR   = 1'b0;
        ptr = (ptr + 1) % NSLOT;
        chk("clr_vs_set_ch_err", 32'(bus.CH_ERR), 32'd1);
        chk("clr_to_err",        32'(bus.TO_ERR), 32'd0);
        bus.ERR_CLR = 1'b1;
        step();
        bus.ERR_CLR = 1'b0;
        chk("ch_err_clr2", 32'(bus.CH_ERR), 32'd0);

        // EN dropped mid-WAIT: conversion completes, then idle
        wait_hold(cyc);
        ch = sched[ptr];
        chk("en_drop_ch_sel", 32'(bus.CH_SEL), 32'(ch));
        repeat (5) step();
        bus.EN = 1'b0;
        repeat (15) step();
        bus.SPI_DONE  = 1'b1;
        bus.DATA_READ = {1'b0, ch, 13'h1FFF};
        step();
        bus.SPI_DONE  = 1'b0;
        bus.DATA_READ = '0;
        ptr = (ptr + 1) % NSLOT;
        chk("en_drop_valid", 32'(bus.VALID), 32'(4'b0001 << ch));
        chk("en_drop_vout",  32'(bus.VOUT),  32'h7FF);
        nh = 0;
        repeat (30) begin
            step();
            if (bus.HOLD === 1'b1) nh++;
        end
        chk("en_drop_no_hold", 32'(nh), 32'd0);

        // Reset in WAIT clears everything immediately; first HOLD afterwards is Vout
        bus.EN = 1'b1;
        wait_hold(cyc);
        repeat (5) step();
        rstn = 1'b0;
        #1;
        chk("mid_rst_hold",   32'(bus.HOLD),   32'd0);
        chk("mid_rst_ch_sel", 32'(bus.CH_SEL), 32'd0);
        chk("mid_rst_vout",   32'(bus.VOUT),   32'd0);
        chk("mid_rst_temp",   32'(bus.TEMP),   32'd0);
        chk("mid_rst_valid",  32'(bus.VALID),  32'd0);
        chk("mid_rst_ch_err", 32'(bus.CH_ERR), 32'd0);
        chk("mid_rst_to_err", 32'(bus.TO_ERR), 32'd0);
        step();
        rstn = 1'b1;
        ptr  = 0;
        wait_hold(cyc);
        chk("post_rst_ch_sel", 32'(bus.CH_SEL), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/adc_chan_sched.md
ADC_CHAN_SCHED -- requirements
Module: adc_chan_sched

Interface
REQ-001 Parameter M, default 12: result width per channel in bits, legal range 1..12.
REQ-002 Parameter GAP, default 4: idle CLK20M cycles between the end of one conversion and the next HOLD pulse.
REQ-003 Parameter TIMEOUT, default 64: maximum CLK20M cycles to wait for SPI_DONE after HOLD.
REQ-004 CLK20M  in  1  block clock, the 20 MHz PLL clock that also drives spi_ad7324.
REQ-005 RSTn  in  1  reset, asynchronous, active-low.
REQ-006 EN  in  1  level; 1 = run the conversion schedule, 0 = finish the current conversion, then idle.
REQ-007 HOLD  out  1  one-cycle start pulse to spi_ad7324.
REQ-008 CH_SEL  out  2  requested channel: 0=Vout, 1=Temp, 2=Vin, 3=Iout.
REQ-009 SPI_DONE  in  1  one-cycle strobe from spi_ad7324; DATA_READ is valid in the same cycle.
REQ-010 DATA_READ  in  16  ADC frame: [14:13] channel ID, [12:0] two's-complement sample.
REQ-011 VOUT, TEMP, VIN, IOUT  out  M each  latest offset-binary result per channel.
REQ-012 VALID  out  4  one-cycle strobe, bit n = channel n result register updated.
REQ-013 CH_ERR  out  1  sticky; returned channel ID differed from CH_SEL.
REQ-014 TO_ERR  out  1  sticky; SPI_DONE not received within TIMEOUT.
REQ-015 ERR_CLR  in  1  synchronous clear of CH_ERR and TO_ERR.

Function
REQ-016 States SHALL be IDLE, START, WAIT, CAPTURE and GAP.
REQ-017 IDLE->START when EN=1; otherwise remain in IDLE.
REQ-018 START SHALL assert HOLD for exactly one cycle with CH_SEL stable, then go to WAIT.
REQ-019 WAIT->CAPTURE on SPI_DONE=1; WAIT->GAP with TO_ERR set when the wait counter reaches TIMEOUT-1 without SPI_DONE.
REQ-020 CH_SEL SHALL be held constant from START until leaving CAPTURE, or until leaving WAIT on timeout.
REQ-021 CAPTURE: if DATA_READ[14:13]==CH_SEL, the result register for that channel is updated and its VALID bit is pulsed; otherwise CH_ERR is set and no register or VALID changes; then go to GAP.
REQ-022 Latency: a result register and VALID SHALL update exactly one cycle after the SPI_DONE cycle.
REQ-023 Result SHALL be DATA_READ[12:13-M] with its MSB inverted (two's complement to offset binary): -4096 -> 0, 0 -> 2^(M-1), +4095 -> all ones.
REQ-024 GAP SHALL last GAP cycles, then advance the schedule pointer and go to START if EN=1, or to IDLE if EN=0.
REQ-025 After a timeout, the schedule pointer SHALL still advance, so no channel blocks the schedule.
REQ-026 The schedule pointer SHALL wrap to the first slot after the last slot.
REQ-027 EN falling in WAIT or CAPTURE SHALL NOT abort the conversion in flight.
REQ-028 An SPI_DONE arriving outside WAIT SHALL be ignored.
REQ-029 ERR_CLR and a new error event in the same cycle: the error flag SHALL read 1.

Reset
REQ-030 RSTn=0 SHALL immediately force IDLE, HOLD=0, CH_SEL=0, schedule pointer=slot 0, all result registers=0, VALID=0, CH_ERR=0, TO_ERR=0, and counters=0.
REQ-031 Reset asserted mid-conversion SHALL discard that conversion; after release the first HOLD is for Vout.

Configuration
REQ-032 Macro ADC_VOUT_PRIORITY_EN defined: 6-slot schedule Vout, Temp, Vout, Vin, Vout, Iout.
REQ-033 Macro ADC_VOUT_PRIORITY_EN undefined: 4-slot round-robin schedule Vout, Temp, Vin, Iout.

Verification
REQ-034 Reset, then EN=1, with SPI_DONE modelled 20 cycles after each HOLD: first HOLD occurs with CH_SEL=0; CH_SEL sequence matches REQ-032/REQ-033 per build and wraps to slot 0.
REQ-035 Frame DATA_READ=16'h1000 (ID 0, sample -4096), M=12 -> VOUT=12'h000 with VALID=4'b0001 one cycle later; frame 16'h0FFF -> VOUT=12'hFFF; frame 16'h0000 -> VOUT=12'h800.
REQ-036 CH_SEL=1 returns ID 2 -> CH_ERR=1, TEMP and VIN unchanged, VALID=0; pulse ERR_CLR -> CH_ERR=0.
REQ-037 No SPI_DONE after HOLD -> TO_ERR=1 on cycle 64 of WAIT; next HOLD follows GAP cycles later with the next channel.
REQ-038 EN dropped during WAIT -> the conversion completes, VALID pulses, then IDLE with no further HOLD; RSTn pulsed low during WAIT -> all outputs 0 immediately.
